// File: rtl/fft_radix2_iter.sv
// fft_radix2_iter: iterative in-place radix-2 DIT FFT, one butterfly per cycle.
// Define FFT_SCALE_EN to halve every butterfly output (overall gain 1/N).
module fft_radix2_iter #(
  parameter int LOG2N   = 3,
  parameter int DATA_W  = 16,
  parameter int TW_FRAC = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  input  logic              start,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic [LOG2N-1:0]  out_index,
  output logic              done
);

  localparam int N    = 1 << LOG2N;
  localparam int HN   = N / 2;
  localparam int TW_W = TW_FRAC + 2;
  localparam int PW   = DATA_W + TW_FRAC + 3;
  localparam int CW   = LOG2N + 1;
  localparam real PI  = 3.14159265358979323846;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    UNLOAD
  } state_t;

  state_t state, state_nx;

  logic signed [DATA_W-1:0] xr [N];
  logic signed [DATA_W-1:0] xi [N];
  logic signed [TW_W-1:0]   wr_rom [HN];
  logic signed [TW_W-1:0]   wi_rom [HN];

  logic [CW-1:0]    load_cnt;
  logic [2:0]       s_cnt;
  logic [LOG2N-2:0] b_cnt;
  logic [LOG2N-1:0] idx;

  logic load_fire;
  logic start_ok;
  logic bfly_last;
  logic out_fire;
  logic out_last;

  // Twiddles are fixed at elaboration; round half away from zero.
  function automatic logic signed [TW_W-1:0] tw(input int k, input bit im);
    real a;
    real v;
    a = 2.0 * PI * real'(k) / real'(N);
    v = (2.0 ** TW_FRAC) * (im ? -$sin(a) : $cos(a));
    return TW_W'((v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v));
  endfunction

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  for (genvar k = 0; k < HN; k++) begin : g_tw
    assign wr_rom[k] = tw(k, 1'b0);
    assign wi_rom[k] = tw(k, 1'b1);
  end

  logic [LOG2N-1:0] bx;
  logic [LOG2N-1:0] mask;
  logic [LOG2N-1:0] half;
  logic [LOG2N-1:0] top_a;
  logic [LOG2N-1:0] bot_a;
  logic [LOG2N-1:0] kx;
  logic [LOG2N-2:0] k_a;
  logic [3:0]       s1;

  always_comb begin
    bx    = {1'b0, b_cnt};
    s1    = {1'b0, s_cnt} + 4'd1;
    half  = LOG2N'(1) << s_cnt;
    mask  = half - LOG2N'(1);
    top_a = ((bx >> s_cnt) << s1) | (bx & mask);
    bot_a = top_a + half;
    kx    = (bx & mask) << (3'(LOG2N - 1) - s_cnt);
    k_a   = kx[LOG2N-2:0];
  end

  logic signed [DATA_W-1:0] tr, ti, br, bi;
  logic signed [DATA_W-1:0] p_r, p_i;
  logic signed [DATA_W-1:0] nt_r, nt_i, nb_r, nb_i;
  logic signed [TW_W-1:0]   wr, wi;
  logic signed [PW-1:0]     brx, bix, wrx, wix, mr, mi;

  assign tr  = xr[top_a];
  assign ti  = xi[top_a];
  assign br  = xr[bot_a];
  assign bi  = xi[bot_a];
  assign wr  = wr_rom[k_a];
  assign wi  = wi_rom[k_a];
  assign brx = PW'(br);
  assign bix = PW'(bi);
  assign wrx = PW'(wr);
  assign wix = PW'(wi);
  assign mr  = (brx * wrx - bix * wix) >>> TW_FRAC;
  assign mi  = (brx * wix + bix * wrx) >>> TW_FRAC;
  assign p_r = mr[DATA_W-1:0];
  assign p_i = mi[DATA_W-1:0];

`ifdef FFT_SCALE_EN
  logic signed [DATA_W:0] st_r, st_i, sb_r, sb_i;
  logic unused_sc;

  // Sum one bit wider, then drop the LSB: a truncating >>>1 with no overflow.
  assign st_r = (DATA_W+1)'(tr) + (DATA_W+1)'(p_r);
  assign st_i = (DATA_W+1)'(ti) + (DATA_W+1)'(p_i);
  assign sb_r = (DATA_W+1)'(tr) - (DATA_W+1)'(p_r);
  assign sb_i = (DATA_W+1)'(ti) - (DATA_W+1)'(p_i);
  assign nt_r = st_r[DATA_W:1];
  assign nt_i = st_i[DATA_W:1];
  assign nb_r = sb_r[DATA_W:1];
  assign nb_i = sb_i[DATA_W:1];
  assign unused_sc = ^{st_r[0], st_i[0], sb_r[0], sb_i[0]};
`else
  assign nt_r = tr + p_r;
  assign nt_i = ti + p_i;
  assign nb_r = tr - p_r;
  assign nb_i = ti - p_i;
`endif

  logic unused_ok;
  assign unused_ok = ^{mr[PW-1:DATA_W], mi[PW-1:DATA_W], kx[LOG2N-1]};

  assign load_fire = in_valid && in_ready;
  assign start_ok  = (state == IDLE) && start && (load_cnt == CW'(N));
  assign bfly_last = (state == COMPUTE) && (s_cnt == 3'(LOG2N - 1)) && (&b_cnt);
  assign out_fire  = (state == UNLOAD) && out_ready;
  assign out_last  = &idx;

  always_ff @(posedge CLK) begin
    if (load_fire) begin
      xr[bitrev(load_cnt[LOG2N-1:0])] <= in_real;
      xi[bitrev(load_cnt[LOG2N-1:0])] <= in_imag;
    end else if (state == COMPUTE) begin
      xr[top_a] <= nt_r;
      xi[top_a] <= nt_i;
      xr[bot_a] <= nb_r;
      xi[bot_a] <= nb_i;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      load_cnt <= '0;
      s_cnt    <= '0;
      b_cnt    <= '0;
      idx      <= '0;
      done     <= 1'b0;
    end else begin
      done <= out_fire && out_last;
      if (load_fire) begin
        load_cnt <= load_cnt + CW'(1);
      end else if (out_fire && out_last) begin
        load_cnt <= '0;
      end
      if (start_ok) begin
        s_cnt <= '0;
        b_cnt <= '0;
      end else if (state == COMPUTE) begin
        b_cnt <= b_cnt + 1'b1;
        if (&b_cnt) s_cnt <= s_cnt + 3'd1;
      end
      if (out_fire) idx <= out_last ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_ok) state_nx = COMPUTE;
      COMPUTE: if (bfly_last) state_nx = UNLOAD;
      UNLOAD:  if (out_fire && out_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    out_real  = '0;
    out_imag  = '0;
    out_index = idx;
    unique case (state)
      IDLE: begin
        busy     = 1'b0;
        in_ready = load_cnt < CW'(N);
      end
      COMPUTE: ;
      UNLOAD: begin
        out_valid = 1'b1;
        out_real  = xr[idx];
        out_imag  = xi[idx];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fft_radix2_iter.sv
// tb_fft_radix2_iter: directed frames against a loop-based FFT model,
// plus literal bin values for impulse, DC, single-tone and wrap cases.
module tb_fft_radix2_iter;

  localparam int LOG2N = 3;
  localparam int N     = 8;
  localparam real PI   = 3.14159265358979323846;

  logic               CLK = 1'b0;
  logic               RST;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_real;
  logic signed [15:0] in_imag;
  logic               start;
  logic               busy;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_real;
  logic signed [15:0] out_imag;
  logic [2:0]         out_index;
  logic               done;

  fft_radix2_iter #(.LOG2N(3), .DATA_W(16), .TW_FRAC(8)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag),
    .start(start), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_real(out_real), .out_imag(out_imag),
    .out_index(out_index), .done(done)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int sr[N], si[N];
  int er[N], ei[N];
  int cr[N], ci[N];
  int exp_idx;
  int done_seen;
  bit mon_en;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic int wrap(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  function automatic int rev3(input int n);
    logic [2:0] a;
    a = n[2:0];
    return int'({a[0], a[1], a[2]});
  endfunction

  // Textbook grouped DIT FFT over the bench's own sample arrays.
  task automatic model();
    int ar[N];
    int ai[N];
    for (int n = 0; n < N; n++) begin
      ar[rev3(n)] = sr[n];
      ai[rev3(n)] = si[n];
    end
    for (int s = 0; s < LOG2N; s++) begin
      int h;
      h = 1 << s;
      for (int g = 0; g < N; g += 2 * h) begin
        for (int j = 0; j < h; j++) begin
          int  t, b, wr, wi, pr, pi, tr, ti;
          real a;
          t  = g + j;
          b  = t + h;
          a  = 2.0 * PI * real'(j * (N / (2 * h))) / real'(N);
          wr = rnd(256.0 * $cos(a));
          wi = -rnd(256.0 * $sin(a));
          pr = wrap((ar[b] * wr - ai[b] * wi) >>> 8);
          pi = wrap((ar[b] * wi + ai[b] * wr) >>> 8);
          tr = ar[t];
          ti = ai[t];
`ifdef FFT_SCALE_EN
          ar[t] = wrap((tr + pr) >>> 1);
          ai[t] = wrap((ti + pi) >>> 1);
          ar[b] = wrap((tr - pr) >>> 1);
          ai[b] = wrap((ti - pi) >>> 1);
`else
          ar[t] = wrap(tr + pr);
          ai[t] = wrap(ti + pi);
          ar[b] = wrap(tr - pr);
          ai[b] = wrap(ti - pi);
`endif
        end
      end
    end
    for (int n = 0; n < N; n++) begin
      er[n] = ar[n];
      ei[n] = ai[n];
    end
  endtask

  always @(negedge CLK) begin
    if (done) done_seen++;
    if (out_valid) begin
      if (!mon_en) begin
        chk("unexpected_out_valid", 1, 0);
      end else if (exp_idx >= N) begin
        chk("extra_bin", exp_idx, N - 1);
      end else begin
        chk("out_index", int'(out_index), exp_idx);
        chk("bin_real", int'(out_real), er[exp_idx]);
        chk("bin_imag", int'(out_imag), ei[exp_idx]);
        cr[exp_idx] = int'(out_real);
        ci[exp_idx] = int'(out_imag);
        if (out_ready) exp_idx++;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input int from, input int cnt);
    for (int i = from; i < from + cnt; i++) begin
      in_valid = 1'b1;
      in_real  = 16'(sr[i]);
      in_imag  = 16'(si[i]);
      @(negedge CLK);
      chk("in_ready_load", int'(in_ready), 1);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 400) begin
      tick();
      cyc++;
    end
  endtask

  // pat 0: out_ready always high; pat 1: ready repeats 1,0,0,1.
  task automatic run(input int pat);
    int cyc;
    model();
    exp_idx   = 0;
    done_seen = 0;
    mon_en    = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    wait_valid(cyc);
    chk("first_valid_latency", cyc, 13);
    cyc = 0;
    while (!done && cyc < 400) begin
      out_ready = (pat == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
      tick();
      cyc++;
    end
    chk("done_high", int'(done), 1);
    chk("busy_at_done", int'(busy), 0);
    chk("in_ready_at_done", int'(in_ready), 1);
    chk("bins_streamed", exp_idx, N);
    mon_en    = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("done_low_after", int'(done), 0);
    chk("done_pulse_count", done_seen, 1);
  endtask

  task automatic set_frame(input int kind);
    for (int n = 0; n < N; n++) begin
      si[n] = 0;
      unique case (kind)
        0: sr[n] = (n == 0) ? 100 : 0;
        1: sr[n] = 100;
        2: sr[n] = (n == 1) ? 256 : 0;
        3: sr[n] = 20000;
        default: begin
          sr[n] = int'($urandom_range(0, 2000)) - 1000;
          si[n] = int'($urandom_range(0, 2000)) - 1000;
        end
      endcase
    end
  endtask

  initial begin
    int cyc;
    RST       = 1'b1;
    in_valid  = 1'b0;
    in_real   = '0;
    in_imag   = '0;
    start     = 1'b0;
    out_ready = 1'b1;
    mon_en    = 1'b0;
    exp_idx   = 0;
    done_seen = 0;
    repeat (2) tick();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_real", int'(out_real), 0);
    chk("rst_out_imag", int'(out_imag), 0);
    chk("rst_out_index", int'(out_index), 0);
    chk("rst_done", int'(done), 0);
    RST = 1'b0;
    tick();

    set_frame(0);
    load(0, N);
    run(0);
    for (int n = 0; n < N; n++) begin
`ifdef FFT_SCALE_EN
      chk("impulse_real", cr[n], 12);
`else
      chk("impulse_real", cr[n], 100);
`endif
      chk("impulse_imag", ci[n], 0);
    end

    set_frame(1);
    load(0, N);
    run(0);
`ifdef FFT_SCALE_EN
    chk("dc_x0_real", cr[0], 100);
`else
    chk("dc_x0_real", cr[0], 800);
`endif
    chk("dc_x0_imag", ci[0], 0);
    chk("dc_x3_real", cr[3], 0);
    chk("dc_x5_imag", ci[5], 0);

    set_frame(2);
    load(0, N);
    run(1);
`ifdef FFT_SCALE_EN
    chk("tone_x1_real", cr[1], 22);
    chk("tone_x1_imag", ci[1], -23);
    chk("tone_x2_imag", ci[2], -32);
    chk("tone_x4_real", cr[4], -32);
`else
    chk("tone_x1_real", cr[1], 181);
    chk("tone_x1_imag", ci[1], -181);
    chk("tone_x2_imag", ci[2], -256);
    chk("tone_x4_real", cr[4], -256);
`endif

    set_frame(3);
    load(0, N);
    run(0);
`ifdef FFT_SCALE_EN
    chk("wrap_x0_real", cr[0], 20000);
`else
    chk("wrap_x0_real", cr[0], 28928);
`endif

    set_frame(4);
    load(0, 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("partial_busy", int'(busy), 0);
    chk("partial_in_ready", int'(in_ready), 1);
    tick();
    chk("partial_no_valid", int'(out_valid), 0);
    load(5, 3);
    chk("full_in_ready", int'(in_ready), 0);
    run(1);

    set_frame(4);
    load(0, N);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst_comp_in_ready", int'(in_ready), 1);
    chk("rst_comp_busy", int'(busy), 0);
    chk("rst_comp_out_valid", int'(out_valid), 0);

    set_frame(4);
    load(0, N);
    model();
    exp_idx   = 0;
    mon_en    = 1'b1;
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(cyc);
    chk("unl_latency", cyc, 13);
    repeat (3) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst_unl_in_ready", int'(in_ready), 1);
    chk("rst_unl_busy", int'(busy), 0);
    chk("rst_unl_out_valid", int'(out_valid), 0);
    chk("rst_unl_out_index", int'(out_index), 0);
    chk("rst_unl_bins_seen", exp_idx, 4);
    mon_en = 1'b0;

    set_frame(4);
    load(0, N);
    run(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
